// File: rtl/fp_pkg.sv
// Shared definitions for the FPU normalise/round stage.
//   - Field widths and exponent constants for IEEE-754 single precision.
//   - Bit positions inside the 28-bit raw mantissa coming out of add/sub:
//       [27] carry, [26] hidden, [25:3] fraction, [2] guard, [1] round, [0] sticky.
//   - State encoding of the normalise/round sequencer.
package fp_pkg;

  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = (1 << EXP_W) - 1;
  localparam int MANT_W  = FRAC_W + 5;

  localparam int CARRY_B = 27;
  localparam int HID_B   = 26;
  localparam int LSB_B   = 3;
  localparam int G_B     = 2;
  localparam int R_B     = 1;
  localparam int S_B     = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/fp_round_rne.sv
// Combinational round-to-nearest-even of a normalised mantissa.
//   mant    : normalised mantissa without the carry bit, [26]=hidden, [25:3]=fraction, [2:0]=GRS
//   exp_in  : 9-bit biased exponent (extra MSB keeps overflow visible)
//   frac    : rounded 23-bit fraction
//   exp_out : exponent field after rounding (0 for denormals, bumped on rounding carry)
//   inexact : any of G/R/S set
//   carry   : rounding carried out of the fraction field
module fp_round_rne
  import fp_pkg::*;
(
  input  logic [HID_B:0]    mant,
  input  logic [EXP_W:0]    exp_in,
  output logic [FRAC_W-1:0] frac,
  output logic [EXP_W:0]    exp_out,
  output logic              inexact,
  output logic              carry
);

  logic            round_up;
  logic [FRAC_W:0] sum;
  logic [EXP_W:0]  exp_base;

  always_comb begin
    // Ties go to the value whose fraction LSB is zero.
    round_up = mant[G_B] & (mant[R_B] | mant[S_B] | mant[LSB_B]);
    sum      = {1'b0, mant[HID_B-1:LSB_B]} + {{FRAC_W{1'b0}}, round_up};
    carry    = sum[FRAC_W];
    // Without a hidden bit the value is denormal and its exponent field is 0.
    exp_base = mant[HID_B] ? exp_in : '0;
    // A carry turns 1.11..1 into 10.0 (normal) or 0.11..1 into 1.0 (denormal
    // becoming the smallest normal); both are exponent+1 with a zero fraction,
    // which is exactly what sum[FRAC_W-1:0] holds in that case.
    exp_out  = exp_base + {{EXP_W{1'b0}}, carry};
    frac     = sum[FRAC_W-1:0];
    inexact  = |mant[G_B:S_B];
  end

endmodule

// File: rtl/fp_normalize_round.sv
// Normalise + RNE-round + pack stage following the FPU add/sub mantissa stage.
// Ports:
//   clk, rst_n        clock (rising edge), synchronous active-low reset
//   in_valid/in_ready raw operand handshake; in_ready is high only when idle
//   mantisa_raw       28-bit raw mantissa {carry, hidden, frac[22:0], G, R, S}
//   sign_result       result sign from add/sub
//   exp_in            biased common exponent
//   out_valid/out_ready result handshake
//   result            packed single {sign, exp[7:0], frac[22:0]}
//   flag_inexact/ovf/unf  status flags, meaningful while out_valid is high
//   dbg_state         current sequencer state
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. Once out_valid rises, result and flags are held until out_ready is seen.
// Only one operation is in flight; in_valid is ignored outside IDLE.
module fp_normalize_round
  import fp_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [MANT_W-1:0]    mantisa_raw,
  input  logic                 sign_result,
  input  logic [EXP_W-1:0]     exp_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+FRAC_W:0] result,
  output logic                 flag_inexact,
  output logic                 flag_ovf,
  output logic                 flag_unf,
  output state_e               dbg_state
);

  localparam logic [EXP_W:0] EXP_ONE = (EXP_W+1)'(1);
  localparam logic [EXP_W:0] EXP_SAT = (EXP_W+1)'(EXP_MAX);

  state_e                  state_q, state_d;
  logic [MANT_W-1:0]       mant_q, mant_d;
  logic [EXP_W:0]          exp_q, exp_d;
  logic                    sign_q, sign_d;
  logic [EXP_W+FRAC_W:0]   result_q, result_d;
  logic                    inexact_q, inexact_d;
  logic                    ovf_q, ovf_d;
  logic                    unf_q, unf_d;
  logic                    out_valid_q, out_valid_d;

  logic [FRAC_W-1:0]       rnd_frac;
  logic [EXP_W:0]          rnd_exp;
  logic                    rnd_inexact;
  logic                    rnd_carry;

  fp_round_rne u_round (
    .mant    (mant_q[HID_B:0]),
    .exp_in  (exp_q),
    .frac    (rnd_frac),
    .exp_out (rnd_exp),
    .inexact (rnd_inexact),
    .carry   (rnd_carry)
  );

  always_comb begin
    state_d     = state_q;
    mant_d      = mant_q;
    exp_d       = exp_q;
    sign_d      = sign_q;
    result_d    = result_q;
    inexact_d   = inexact_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    out_valid_d = out_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          mant_d    = mantisa_raw;
          exp_d     = {1'b0, exp_in};
          sign_d    = sign_result;
          inexact_d = 1'b0;
          ovf_d     = 1'b0;
          unf_d     = 1'b0;
          state_d   = ST_NORM;
        end
      end

      ST_NORM: begin
        if (mant_q == '0) begin
          state_d = ST_ROUND;
        end else if (mant_q[CARRY_B]) begin
          // The bit shifted out folds into sticky so rounding still sees it.
          mant_d  = {1'b0, mant_q[CARRY_B:2], mant_q[R_B] | mant_q[S_B]};
          exp_d   = exp_q + EXP_ONE;
          state_d = ST_ROUND;
        end else if (mant_q[HID_B] || (exp_q <= EXP_ONE)) begin
          // Exponent floor reached without a hidden bit: leave it denormal.
          state_d = ST_ROUND;
        end else begin
          mant_d = {mant_q[MANT_W-2:0], 1'b0};
          exp_d  = exp_q - EXP_ONE;
        end
      end

      ST_ROUND: begin
        if (mant_q == '0) begin
          result_d  = '0;
          inexact_d = 1'b0;
          ovf_d     = 1'b0;
          unf_d     = 1'b0;
        end else if (rnd_exp >= EXP_SAT) begin
          result_d  = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
          inexact_d = 1'b1;
          ovf_d     = 1'b1;
          unf_d     = 1'b0;
        end else begin
          result_d  = {sign_q, rnd_exp[EXP_W-1:0], rnd_frac};
          inexact_d = rnd_inexact;
          ovf_d     = 1'b0;
          // Tiny means the packed result is still denormal/zero; a denormal
          // that rounds up into the smallest normal is not tiny.
          unf_d     = rnd_inexact & ~mant_q[HID_B] & ~rnd_carry;
        end
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end

      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mant_q      <= '0;
      exp_q       <= '0;
      sign_q      <= 1'b0;
      result_q    <= '0;
      inexact_q   <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mant_q      <= mant_d;
      exp_q       <= exp_d;
      sign_q      <= sign_d;
      result_q    <= result_d;
      inexact_q   <= inexact_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready     = (state_q == ST_IDLE);
  assign out_valid    = out_valid_q;
  assign result       = result_q;
  assign flag_inexact = inexact_q;
  assign flag_ovf     = ovf_q;
  assign flag_unf     = unf_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_fp_normalize_round.sv
// Directed bench for fp_normalize_round: hand-computed vectors, latency,
// backpressure and mid-operation reset.
module tb_fp_normalize_round;
  import fp_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        sign_result = 1'b0;
  logic [27:0] mantisa_raw = '0;
  logic [7:0]  exp_in = '0;
  logic        in_ready, out_valid, flag_inexact, flag_ovf, flag_unf;
  logic [31:0] result;
  state_e      dbg_state;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  fp_normalize_round dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .mantisa_raw  (mantisa_raw),
    .sign_result  (sign_result),
    .exp_in       (exp_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .flag_inexact (flag_inexact),
    .flag_ovf     (flag_ovf),
    .flag_unf     (flag_unf),
    .dbg_state    (dbg_state)
  );

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- driver + collector ----------------
  // flags packed as {inexact, ovf, unf}; exp_lat counts edges from accept to out_valid.
  task automatic run_op(input string tag, input logic [27:0] m, input logic [7:0] e,
                        input logic s, input logic [31:0] exp_res, input int exp_lat,
                        input logic [2:0] exp_flags, input int hold);
    int lat;
    logic [31:0] want;
    exp_q.push_back(exp_res);
    @(negedge clk);
    check({tag, "/in_ready"}, 32'(in_ready), 32'd1);
    mantisa_raw = m;
    exp_in = e;
    sign_result = s;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check({tag, "/flags_cleared"}, 32'({flag_inexact, flag_ovf, flag_unf}), 32'd0);
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    want = exp_q.pop_front();
    if (!out_valid) begin
      check({tag, "/timeout"}, 32'(out_valid), 32'd1);
      do_reset();
      return;
    end
    check({tag, "/result"}, result, want);
    check({tag, "/flags"}, 32'({flag_inexact, flag_ovf, flag_unf}), 32'(exp_flags));
    for (int i = 0; i < hold; i++) begin
      // A competing operand must not be taken while the result waits.
      in_valid = 1'b1;
      mantisa_raw = 28'h8000000;
      @(negedge clk);
      check({tag, "/hold_result"}, result, want);
      check({tag, "/hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "/hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check({tag, "/valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "/idle_again"}, 32'(in_ready), 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    do_reset();
    @(negedge clk);
    check("reset/out_valid", 32'(out_valid), 32'd0);
    check("reset/result", result, 32'h0);
    check("reset/flags", 32'({flag_inexact, flag_ovf, flag_unf}), 32'd0);
    check("reset/in_ready", 32'(in_ready), 32'd1);

    // 1.0 already normalised
    run_op("one",       28'h4000000, 8'd127, 1'b0, 32'h3F800000, 2,  3'b000, 0);
    run_op("neg_one",   28'h4000000, 8'd127, 1'b1, 32'hBF800000, 2,  3'b000, 0);
    // carry bit set: one right shift, exponent 128
    run_op("rshift",    28'h8000000, 8'd127, 1'b0, 32'h40000000, 2,  3'b000, 0);
    // bit 3 to bit 26 takes 23 left shifts, exponent 127-23=104=0x68
    run_op("lshift23",  28'h0000008, 8'd127, 1'b0, 32'h34000000, 25, 3'b000, 0);
    // RNE: tie with even LSB stays, tie with odd LSB rounds up, all-ones carries
    run_op("rne_tie_even", 28'h4000004, 8'd127, 1'b0, 32'h3F800000, 2, 3'b100, 0);
    run_op("rne_tie_odd",  28'h400000C, 8'd127, 1'b0, 32'h3F800002, 2, 3'b100, 0);
    run_op("rne_carry",    28'h7FFFFFC, 8'd127, 1'b0, 32'h40000000, 2, 3'b100, 0);
    // right shift to exponent 255 saturates to infinity
    run_op("overflow",  28'h8000000, 8'd254, 1'b0, 32'h7F800000, 2,  3'b110, 0);
    // exponent floor: one ulp of bit 3 at exponent 1 is the smallest denormal
    run_op("denorm_min", 28'h0000008, 8'd1, 1'b0, 32'h00000001, 2,  3'b000, 0);
    // exponent 2: one left shift to exponent 1, value 2^-148 = two denormal ulps
    run_op("denorm_shift", 28'h0000008, 8'd2, 1'b0, 32'h00000002, 3, 3'b000, 0);
    // only the guard bit left in a denormal: -0 with inexact and underflow
    run_op("denorm_unf", 28'h0000004, 8'd1, 1'b1, 32'h80000000, 2,  3'b101, 0);
    // denormal rounding up into the smallest normal: not tiny afterwards
    run_op("denorm_carry", 28'h3FFFFFC, 8'd1, 1'b0, 32'h00800000, 2, 3'b100, 0);
    // zero mantissa packs +0 regardless of sign
    run_op("zero",      28'h0000000, 8'd127, 1'b1, 32'h00000000, 2,  3'b000, 0);
    // backpressure: result held for 5 cycles with out_ready low
    run_op("backpress", 28'h4000000, 8'd128, 1'b0, 32'h40000000, 2,  3'b000, 5);

    // reset in the middle of a long normalisation
    @(negedge clk);
    mantisa_raw = 28'h0000008;
    exp_in = 8'd127;
    sign_result = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst/in_norm", 32'(dbg_state), 32'(ST_NORM));
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst/out_valid", 32'(out_valid), 32'd0);
    check("midrst/result", result, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst/in_ready", 32'(in_ready), 32'd1);
    repeat (30) @(negedge clk);
    check("midrst/abandoned", 32'(out_valid), 32'd0);

    run_op("after_rst", 28'h400000C, 8'd127, 1'b1, 32'hBF800002, 2, 3'b100, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
